// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: a granted client holds the shared port for up to
// its weight in counted beats (or until it drops req), then priority rotates.
module wrr_burst_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int WEIGHT_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLIENTS-1:0]          req,
  input  logic [NUM_CLIENTS-1:0]          beat,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weight,
  output logic [NUM_CLIENTS-1:0]          grant,
  output logic                            grant_valid,
  output logic [$clog2(NUM_CLIENTS)-1:0]  grant_id
);

  localparam int IDW = $clog2(NUM_CLIENTS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]    qcnt_q, qcnt_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   grant_valid_q, grant_valid_d;

  logic                   any_req_s;
  logic                   counted_s;
  logic                   release_s;
  logic [IDW-1:0]         next_ptr_s;
  logic [IDW-1:0]         sel_idle_s;
  logic [IDW-1:0]         sel_next_s;

  // First requester at or after p, wrapping past the last client.
  function automatic logic [IDW-1:0] sel_f(input logic [NUM_CLIENTS-1:0] r,
                                           input logic [IDW-1:0] p);
    logic [IDW-1:0] res;
    logic [IDW-1:0] idx;
    logic [IDW:0]   sum;
    logic           found;
    res   = {IDW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      sum = {1'b0, p} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_CLIENTS)) begin
        sum = sum - (IDW+1)'(NUM_CLIENTS);
      end
      idx = sum[IDW-1:0];
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Quantum of client g; a zero weight still buys one beat.
  function automatic logic [WEIGHT_W-1:0] quantum_f(input logic [NUM_CLIENTS*WEIGHT_W-1:0] w,
                                                    input logic [IDW-1:0] g);
    logic [WEIGHT_W-1:0] v;
    v = {WEIGHT_W{1'b0}};
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (IDW'(i) == g) begin
        v = w[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    if (v == {WEIGHT_W{1'b0}}) begin
      v = {{(WEIGHT_W-1){1'b0}}, 1'b1};
    end
    return v;
  endfunction

  function automatic logic [NUM_CLIENTS-1:0] onehot_f(input logic [IDW-1:0] g);
    return {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << g;
  endfunction

  // Release detection and candidate selection for both the idle and hand-over paths.
  always_comb begin
    any_req_s  = |req;
    counted_s  = beat[grant_id_q] & req[grant_id_q];
    release_s  = ~req[grant_id_q] | (counted_s & (qcnt_q == {{(WEIGHT_W-1){1'b0}}, 1'b1}));
    if (grant_id_q == IDW'(NUM_CLIENTS - 1)) begin
      next_ptr_s = {IDW{1'b0}};
    end else begin
      next_ptr_s = grant_id_q + IDW'(1);
    end
    sel_idle_s = sel_f(req, ptr_q);
    sel_next_s = sel_f(req, next_ptr_s);
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    qcnt_d        = qcnt_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d       = GRANT;
          grant_d       = onehot_f(sel_idle_s);
          grant_id_d    = sel_idle_s;
          grant_valid_d = 1'b1;
          qcnt_d        = quantum_f(weight, sel_idle_s);
        end else begin
          grant_d       = {NUM_CLIENTS{1'b0}};
          grant_id_d    = {IDW{1'b0}};
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_d = next_ptr_s;
          // Hand over on the same edge; a lone requester is re-granted here.
          if (any_req_s) begin
            grant_d       = onehot_f(sel_next_s);
            grant_id_d    = sel_next_s;
            grant_valid_d = 1'b1;
            qcnt_d        = quantum_f(weight, sel_next_s);
          end else begin
            state_d       = IDLE;
            grant_d       = {NUM_CLIENTS{1'b0}};
            grant_id_d    = {IDW{1'b0}};
            grant_valid_d = 1'b0;
            qcnt_d        = {WEIGHT_W{1'b0}};
          end
        end else if (counted_s) begin
          qcnt_d = qcnt_q - {{(WEIGHT_W-1){1'b0}}, 1'b1};
        end else begin
          qcnt_d = qcnt_q;
        end
      end
      default: begin
        state_d       = IDLE;
        ptr_d         = {IDW{1'b0}};
        qcnt_d        = {WEIGHT_W{1'b0}};
        grant_d       = {NUM_CLIENTS{1'b0}};
        grant_id_d    = {IDW{1'b0}};
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= {IDW{1'b0}};
      qcnt_q        <= {WEIGHT_W{1'b0}};
      grant_q       <= {NUM_CLIENTS{1'b0}};
      grant_id_q    <= {IDW{1'b0}};
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      qcnt_q        <= qcnt_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an integer-level model of the arbitration rules.
module tb_wrr_burst_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  beat;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: current holder (-1 = idle), beats left in its quantum, rotate pointer.
  int m_cur  = -1;
  int m_left = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(.NUM_CLIENTS(N), .WEIGHT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .beat(beat), .weight(weight),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic int wt(input int i);
    int v;
    v = int'((weight >> (i * WW)) & 16'h000f);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cur  = -1;
    m_left = 0;
    m_ptr  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] b);
    bit done;
    if (m_cur < 0) begin
      if (r != 4'b0000) begin
        m_cur  = pick(m_ptr, r);
        m_left = wt(m_cur);
      end
    end else begin
      done = !r[m_cur] || (b[m_cur] && m_left == 1);
      if (done) begin
        m_ptr = (m_cur + 1) % N;
        if (r != 4'b0000) begin
          m_cur  = pick(m_ptr, r);
          m_left = wt(m_cur);
        end else begin
          m_cur = -1;
        end
      end else if (b[m_cur]) begin
        m_left--;
      end
    end
  endtask

  // One clock: apply inputs, advance the model after the edge, return on the falling edge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] b);
    req  = r;
    beat = b;
    @(posedge clk);
    #1;
    if (rst_n) model_step(r, b);
    else       model_reset();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock.
  task automatic reset_async();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_valid", 32'(grant_valid), 32'd0);
    check("async_rst_id", 32'(grant_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("grant", 32'(grant), (m_cur < 0) ? 32'd0 : (32'd1 << m_cur));
        check("grant_valid", 32'(grant_valid), (m_cur < 0) ? 32'd0 : 32'd1);
        check("grant_id", 32'(grant_id), (m_cur < 0) ? 32'd0 : 32'(m_cur));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq2 [5];
    logic [3:0] seq3 [10];
    seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq3 = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000,
             4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    rst_n  = 1'b1;
    req    = 4'b0000;
    beat   = 4'b0000;
    weight = 16'h1111;
    #1;
    rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // Reset held with every client requesting.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 4'b1111);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_id", 32'(grant_id), 32'd0);
    end
    rst_n = 1'b1;

    // Unit weights, full load: one beat each in strict rotation.
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b1111);
      check("t2_rotation", 32'(grant), 32'(seq2[i]));
    end

    // Client 1 weight 3.
    weight = 16'h1131;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b1111, 4'b1111);
      check("t3_weighted", 32'(grant), 32'(seq3[i]));
    end

    // Lone requester re-granted back-to-back.
    weight = 16'h1211;
    cyc(4'b0100, 4'b0100);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0100, 4'b0100);
      check("t4_lone_grant", 32'(grant), 32'h4);
      check("t4_lone_id", 32'(grant_id), 32'd2);
    end

    // Early withdrawal hands over and rotates the pointer.
    reset_async();
    weight = 16'h1114;
    cyc(4'b0011, 4'b0001);
    check("t5_first", 32'(grant), 32'h1);
    cyc(4'b0011, 4'b0001);
    check("t5_hold", 32'(grant), 32'h1);
    cyc(4'b0010, 4'b0000);
    check("t5_drop", 32'(grant), 32'h2);
    check("t5_drop_id", 32'(grant_id), 32'd1);
    cyc(4'b0011, 4'b0010);
    check("t5_back_to_0", 32'(grant), 32'h1);

    // Foreign beats ignored; then async reset mid-grant.
    reset_async();
    weight = 16'h1112;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1001, 4'b1000);
      check("t6_foreign_beat", 32'(grant), 32'h1);
    end
    cyc(4'b1001, 4'b0001);
    check("t6_count1", 32'(grant), 32'h1);
    cyc(4'b1001, 4'b0001);
    check("t6_quantum_end", 32'(grant), 32'h8);
    cyc(4'b1001, 4'b0000);
    check("t6_hold3", 32'(grant), 32'h8);
    reset_async();
    cyc(4'b1111, 4'b0000);
    check("t6_after_rst", 32'(grant), 32'h1);

    // Random traffic including zero weights, idle gaps and a mid-run reset.
    weight = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
      if ($urandom_range(0, 9) == 0) r = 4'b0000;
      else r = 4'($urandom_range(0, 15));
      if (i == 200) reset_async();
      cyc(r, 4'($urandom_range(0, 15)));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
